// File: rtl/int_pkg.sv
// Shared constants for the interrupt controller: register offsets, source ids,
// FSM encodings and control-bit positions.
package int_pkg;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PEND   = 3'd1;
  localparam logic [2:0] OFF_RELOAD = 3'd2;
  localparam logic [2:0] OFF_TCTRL  = 3'd3;
  localparam logic [2:0] OFF_TCOUNT = 3'd4;
  localparam logic [15:0] WIN_WORDS = 16'd5;

  localparam int SRC_TMR  = 0;
  localparam int SRC_EXT0 = 1;
  localparam int SRC_EXT1 = 2;
  localparam int SRC_EXT2 = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SERV = 2'd2;

  localparam int CTRL_GIE   = 15;
  localparam int TCTRL_TEN  = 0;
  localparam int TCTRL_AUTO = 1;

  // Lowest set index wins; the timer (bit 0) has top priority.
  function automatic logic [1:0] prio_enc(input logic [3:0] v);
    logic [1:0] idx;
    if (v[0])      idx = 2'd0;
    else if (v[1]) idx = 2'd1;
    else if (v[2]) idx = 2'd2;
    else           idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/irq_timer.sv
// Down-counting interrupt timer with reload register and TEN/AUTO control.
// Tick is combinational from state (count==0 while enabled); period is RELOAD+1 cycles.
// No backpressure: the tick pulse is a single-cycle event consumed by the pending register.
module irq_timer
  import int_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        reload_we,
  input  logic        tctrl_we,
  input  logic [15:0] wdata,
  output logic [15:0] reload,
  output logic        ten,
  output logic        auto_rl,
  output logic [15:0] count,
  output logic        tick
);

  logic load;

  assign tick = ten && (count == 16'd0);
  // Only an off-to-on transition of TEN restarts the count.
  assign load = tctrl_we && wdata[TCTRL_TEN] && !ten;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reload  <= '0;
      ten     <= 1'b0;
      auto_rl <= 1'b0;
      count   <= '0;
    end else begin
      if (reload_we)
        reload <= wdata;

      if (tctrl_we) begin
        ten     <= wdata[TCTRL_TEN];
        auto_rl <= wdata[TCTRL_AUTO];
      end else if (tick && !auto_rl) begin
        ten <= 1'b0;
      end

      if (load)
        count <= reload;
      else if (tick)
        count <= auto_rl ? reload : count;
      else if (ten)
        count <= count - 16'd1;
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: 3 synchronised edge-triggered IRQs plus timer, fixed priority, one-deep service.
// int_req rises one cycle after a pending source becomes eligible; holds until int_ack or withdrawal.
module int_ctrl
  import int_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter logic [9:0]  VEC_BASE    = 10'h3C0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  ext_irq,
  input  logic        io_we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic        int_ack,
  input  logic        reti,
  output logic        int_req,
  output logic [9:0]  int_vec,
  output logic        in_service
);

  logic [15:0] off;
  logic        in_win;
  logic [2:0]  sel;
  logic        we_ctrl, we_pend, we_reload, we_tctrl;

  assign off       = addr - BASE_ADDR;
  assign in_win    = off < WIN_WORDS;
  assign sel       = off[2:0];
  assign we_ctrl   = io_we && in_win && (sel == OFF_CTRL);
  assign we_pend   = io_we && in_win && (sel == OFF_PEND);
  assign we_reload = io_we && in_win && (sel == OFF_RELOAD);
  assign we_tctrl  = io_we && in_win && (sel == OFF_TCTRL);

  logic [15:0] tmr_reload, tmr_count;
  logic        tmr_ten, tmr_auto, tmr_tick;

  irq_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .reload_we (we_reload),
    .tctrl_we  (we_tctrl),
    .wdata     (wdata),
    .reload    (tmr_reload),
    .ten       (tmr_ten),
    .auto_rl   (tmr_auto),
    .count     (tmr_count),
    .tick      (tmr_tick)
  );

  // Synchroniser chain (element 0 is the first flop) plus one flop for edge detect.
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [2:0]                  sync_last_q;
  logic [2:0]                  ext_rise;

  assign ext_rise = sync_q[SYNC_STAGES-1] & ~sync_last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q      <= '0;
      sync_last_q <= '0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], ext_irq};
      sync_last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  logic       gie_q, gie_nxt;
  logic [3:0] mask_q, mask_nxt;
  logic [3:0] pend_q, pend_nxt;
  logic [3:0] set_vec, w1c_clr, ack_clr, elig;
  logic [1:0] state_q, state_nxt;
  logic [1:0] win_q, win_nxt;
  logic [9:0] vec_q;

  always_comb begin
    set_vec = '0;
    set_vec[SRC_TMR]  = tmr_tick;
    set_vec[SRC_EXT0] = ext_rise[0];
    set_vec[SRC_EXT1] = ext_rise[1];
    set_vec[SRC_EXT2] = ext_rise[2];
  end

  assign w1c_clr  = we_pend ? wdata[3:0] : 4'b0000;
  assign ack_clr  = (state_q == ST_REQ && int_ack) ? (4'b0001 << win_q) : 4'b0000;
  // A set event in the same cycle as any clear leaves the bit set.
  assign pend_nxt = (pend_q & ~w1c_clr & ~ack_clr) | set_vec;
  assign gie_nxt  = we_ctrl ? wdata[CTRL_GIE] : gie_q;
  assign mask_nxt = we_ctrl ? wdata[3:0] : mask_q;
  assign elig     = pend_q & mask_q & {4{gie_q}};

  always_comb begin
    state_nxt = state_q;
    win_nxt   = win_q;
    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          state_nxt = ST_REQ;
          win_nxt   = prio_enc(elig);
        end
      end
      ST_REQ: begin
        // Withdrawal looks at next-cycle enables so int_req drops right after the offending write.
        if (int_ack)
          state_nxt = ST_SERV;
        else if (!(gie_nxt && mask_nxt[win_q] && pend_nxt[win_q]))
          state_nxt = ST_IDLE;
      end
      ST_SERV: begin
        if (reti)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gie_q   <= 1'b0;
      mask_q  <= '0;
      pend_q  <= '0;
      state_q <= ST_IDLE;
      win_q   <= '0;
      vec_q   <= VEC_BASE;
    end else begin
      gie_q   <= gie_nxt;
      mask_q  <= mask_nxt;
      pend_q  <= pend_nxt;
      state_q <= state_nxt;
      win_q   <= win_nxt;
      if (state_q == ST_IDLE && state_nxt == ST_REQ)
        vec_q <= VEC_BASE + {6'd0, win_nxt, 2'b00};
    end
  end

  assign int_req    = (state_q == ST_REQ);
  assign in_service = (state_q == ST_SERV);
  assign int_vec    = vec_q;

  always_comb begin
    rdata = '0;
    if (in_win) begin
      case (sel)
        OFF_CTRL:   rdata = {gie_q, 11'd0, mask_q};
        OFF_PEND:   rdata = {12'd0, pend_q};
        OFF_RELOAD: rdata = tmr_reload;
        OFF_TCTRL:  rdata = {14'd0, tmr_auto, tmr_ten};
        OFF_TCOUNT: rdata = tmr_count;
        default:    rdata = '0;
      endcase
    end
  end

endmodule
